// File: rtl/elevator_pkg.sv
// Shared encodings and floor-mask helpers for the five-landing elevator controller.
package elevator_pkg;

    localparam int         NUM_FLOORS = 5;
    localparam logic [2:0] TOP_FLOOR  = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR_OPEN = 3'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP   = 2'd0,
        DIR_DOWN = 2'd1,
        DIR_IDLE = 2'd2
    } dir_e;

    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [2:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (3'(i) == f);
        end
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [2:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (3'(i) > f);
        end
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [2:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (3'(i) < f);
        end
        return m;
    endfunction

    // Distance to the nearest pending floor above f (0 when there is none).
    function automatic logic [2:0] dist_above(input logic [NUM_FLOORS-1:0] p, input logic [2:0] f);
        logic [2:0] d;
        d = 3'd0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (p[i] && (3'(i) > f)) begin
                d = 3'(i) - f;
            end
        end
        return d;
    endfunction

    function automatic logic [2:0] dist_below(input logic [NUM_FLOORS-1:0] p, input logic [2:0] f);
        logic [2:0] d;
        d = 3'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (p[i] && (3'(i) < f)) begin
                d = f - 3'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// Call-button capture: registers each button, detects rising edges and holds them as pending requests.
module elevator_req_latch
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req_i,
    input  logic [NUM_FLOORS-1:0] clr_i,
    output logic [NUM_FLOORS-1:0] pending_o
);

    logic [NUM_FLOORS-1:0] req_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;

    // A clear strobe wins over a same-cycle edge so a call at the serving floor is absorbed.
    always_comb begin
        pending_d = (pending_q | (req_i & ~req_q)) & ~clr_i;
    end

    // Button history and pending vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= {NUM_FLOORS{1'b0}};
            pending_q <= {NUM_FLOORS{1'b0}};
        end else begin
            req_q     <= req_i;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/elevator_4stage.sv
// Five-landing collective (SCAN) elevator controller: FSM, travel/door timer and floor counter.
module elevator_4stage
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rgnd,
    input  logic       r1st,
    input  logic       r2nd,
    input  logic       r3rd,
    input  logic       r4th,
    output logic [2:0] floor,
    output logic [2:0] state,
    output logic [1:0] dir
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [2:0]            floor_q, floor_d, nxt_floor_s;
    logic [TW-1:0]         timer_q, timer_d;
    logic [NUM_FLOORS-1:0] req_s, pending_s, clr_s;
    logic                  here_s, up_s, dn_s, near_up_s;
    logic                  arr_here_s, arr_up_s, arr_dn_s, ahead_s, behind_s;

    assign req_s = {r4th, r3rd, r2nd, r1st, rgnd};

    elevator_req_latch u_req_latch (
        .clk       (clk),
        .rst_n     (rst),
        .req_i     (req_s),
        .clr_i     (clr_s),
        .pending_o (pending_s)
    );

    // Request summary at the current floor and at the floor the car is about to reach.
    always_comb begin
        here_s    = |(pending_s & floor_bit(floor_q));
        up_s      = |(pending_s & above_mask(floor_q));
        dn_s      = |(pending_s & below_mask(floor_q));
        near_up_s = up_s && (!dn_s || (dist_above(pending_s, floor_q) <= dist_below(pending_s, floor_q)));
        if ((state_q == MOVE_UP) && (floor_q < TOP_FLOOR)) begin
            nxt_floor_s = floor_q + 3'd1;
        end else if ((state_q == MOVE_DOWN) && (floor_q > 3'd0)) begin
            nxt_floor_s = floor_q - 3'd1;
        end else begin
            nxt_floor_s = floor_q;
        end
        arr_here_s = |(pending_s & floor_bit(nxt_floor_s));
        arr_up_s   = |(pending_s & above_mask(nxt_floor_s));
        arr_dn_s   = |(pending_s & below_mask(nxt_floor_s));
        ahead_s    = (state_q == MOVE_UP) ? arr_up_s : arr_dn_s;
        behind_s   = (state_q == MOVE_UP) ? arr_dn_s : arr_up_s;
    end

    // Next-state, direction, floor, timer and pending-clear decisions.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        timer_d = timer_q;
        clr_s   = {NUM_FLOORS{1'b0}};
        case (state_q)
            IDLE: begin
                dir_d   = DIR_IDLE;
                timer_d = {TW{1'b0}};
                if (here_s) begin
                    state_d = DOOR_OPEN;
                    clr_s   = floor_bit(floor_q);
                end else if (up_s || dn_s) begin
                    state_d = near_up_s ? MOVE_UP : MOVE_DOWN;
                    dir_d   = near_up_s ? DIR_UP : DIR_DOWN;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = {TW{1'b0}};
                    floor_d = nxt_floor_s;
                    if (arr_here_s) begin
                        state_d = DOOR_OPEN;
                        clr_s   = floor_bit(nxt_floor_s);
                    end else if (ahead_s) begin
                        state_d = state_q;
                    end else if (behind_s) begin
                        state_d = (state_q == MOVE_UP) ? MOVE_DOWN : MOVE_UP;
                        dir_d   = (state_q == MOVE_UP) ? DIR_DOWN : DIR_UP;
                    end else begin
                        state_d = IDLE;
                        dir_d   = DIR_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DOOR_OPEN: begin
                clr_s = floor_bit(floor_q);
                if (timer_q == DOOR_LAST) begin
                    timer_d = {TW{1'b0}};
                    if (up_s && ((dir_q == DIR_UP) || ((dir_q == DIR_DOWN) && !dn_s) ||
                                 ((dir_q == DIR_IDLE) && near_up_s))) begin
                        state_d = MOVE_UP;
                        dir_d   = DIR_UP;
                    end else if (dn_s) begin
                        state_d = MOVE_DOWN;
                        dir_d   = DIR_DOWN;
                    end else begin
                        state_d = IDLE;
                        dir_d   = DIR_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dir_d   = DIR_IDLE;
                timer_d = {TW{1'b0}};
            end
        endcase
    end

    // Controller state registers; these drive the outputs directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_IDLE;
            floor_q <= 3'd0;
            timer_q <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            timer_q <= timer_d;
        end
    end

    assign floor = floor_q;
    assign state = state_q;
    assign dir   = dir_q;

endmodule

// File: tb/tb_elevator_4stage.sv
// Scoreboard bench for elevator_4stage: a floor/phase reference model predicts every output change.
module tb_elevator_4stage;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [2:0] floor, state;
    logic [1:0] dir;

    always #5 clk = ~clk;

    elevator_4stage #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
        .clk(clk), .rst(rst),
        .rgnd(req[0]), .r1st(req[1]), .r2nd(req[2]), .r3rd(req[3]), .r4th(req[4]),
        .floor(floor), .state(state), .dir(dir)
    );

    typedef struct {int fl; int st; int dr; int cyc;} exp_t;
    exp_t exp_q[$];

    int n_checks = 0, n_fail = 0, cyc = 0;
    // Reference model: floor, phase (0 idle,1 up,2 down,3 door), direction, phase start cycle.
    int m_fl = 0, m_st = 0, m_dr = 2, m_seg = 0;
    logic [4:0] m_pend = 5'd0, m_prev = 5'd0;
    int p_fl = 0, p_st = 0, p_dr = 2;
    bit mon_en = 1'b0;
    logic [7:0] last_seen = {3'd0, 3'd0, 2'd2};

    function automatic bit any_pend(input int lo, input int hi);
        for (int i = 0; i < 5; i++) begin
            if (i >= lo && i <= hi && m_pend[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Nearest pending floor other than the current one; upward wins ties; -1 if none.
    function automatic int nearest_target();
        int best = -1;
        for (int d = 1; d <= 4; d++) begin
            if (best < 0 && m_fl + d <= 4 && m_pend[m_fl + d]) best = m_fl + d;
            if (best < 0 && m_fl - d >= 0 && m_pend[m_fl - d]) best = m_fl - d;
        end
        return best;
    endfunction

    function automatic void push_if_changed();
        exp_t e;
        if (m_fl != p_fl || m_st != p_st || m_dr != p_dr) begin
            e.fl = m_fl; e.st = m_st; e.dr = m_dr; e.cyc = cyc;
            exp_q.push_back(e);
            p_fl = m_fl; p_st = m_st; p_dr = m_dr;
        end
    endfunction

    function automatic void go(input int d);
        m_dr  = d;
        m_st  = (d == 0) ? 1 : ((d == 1) ? 2 : 0);
        m_seg = cyc;
    endfunction

    function automatic void model_reset();
        m_fl = 0; m_st = 0; m_dr = 2; m_seg = cyc;
        m_pend = 5'd0; m_prev = 5'd0;
        push_if_changed();
    endfunction

    function automatic void model_step();
        logic [4:0] e;
        int clr, el, t;
        bit above, below;
        clr = -1;
        el  = cyc - m_seg;
        e   = req & ~m_prev;
        if (m_st == 0) begin
            if (m_pend[m_fl]) begin
                m_st = 3; m_seg = cyc; clr = m_fl;
            end else begin
                t = nearest_target();
                if (t >= 0) go((t > m_fl) ? 0 : 1);
            end
        end else if (m_st == 1 || m_st == 2) begin
            if (el == TRAVEL) begin
                m_fl  = m_fl + ((m_st == 1) ? 1 : -1);
                m_seg = cyc;
                above = any_pend(m_fl + 1, 4);
                below = any_pend(0, m_fl - 1);
                if (m_pend[m_fl]) begin
                    m_st = 3; clr = m_fl;
                end else if ((m_st == 1) ? above : below) begin
                    m_st = m_st;
                end else if ((m_st == 1) ? below : above) begin
                    go((m_st == 1) ? 1 : 0);
                end else begin
                    go(2);
                end
            end
        end else begin
            clr = m_fl;
            if (el == DOOR) begin
                above = any_pend(m_fl + 1, 4);
                below = any_pend(0, m_fl - 1);
                if (m_dr == 0) go(above ? 0 : (below ? 1 : 2));
                else if (m_dr == 1) go(below ? 1 : (above ? 0 : 2));
                else begin
                    t = nearest_target();
                    go((t < 0) ? 2 : ((t > m_fl) ? 0 : 1));
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            m_pend[i] = (m_pend[i] | e[i]) & (i != clr);
        end
        m_prev = req;
        push_if_changed();
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst === 1'b1) model_step();
        end
    end

    // Monitor: every change of the DUT outputs is matched against the next predicted change.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if ({floor, state, dir} !== last_seen) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got floor=%0d state=%0d dir=%0d at cycle %0d, required no change",
                             floor, state, dir, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.fl != int'(floor) || e.st != int'(state) || e.dr != int'(dir) || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL output_seq: got floor=%0d state=%0d dir=%0d cycle=%0d, required floor=%0d state=%0d dir=%0d cycle=%0d",
                                 floor, state, dir, cyc, e.fl, e.st, e.dr, e.cyc);
                    end
                end
                last_seen = {floor, state, dir};
            end
        end
    end

    task automatic check_now(input string name, input int f, input int s, input int d);
        n_checks++;
        if (int'(floor) != f || int'(state) != s || int'(dir) != d) begin
            n_fail++;
            $display("FAIL %s: got floor=%0d state=%0d dir=%0d, required floor=%0d state=%0d dir=%0d",
                     name, floor, state, dir, f, s, d);
        end
    endtask

    task automatic press(input logic [4:0] m, input int hold);
        @(negedge clk); #1;
        req = req | m;
        repeat (hold) @(negedge clk);
        #1;
        req = req & ~m;
    endtask

    task automatic wait_dut(input int f, input int s, input int budget, input string name);
        int n = 0;
        while (!(int'(floor) == f && int'(state) == s)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                n_checks++; n_fail++;
                $display("FAIL %s: timeout, got floor=%0d state=%0d, required floor=%0d state=%0d",
                         name, floor, state, f, s);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(m_st == 0 && m_pend == 5'd0 && req == 5'd0 && int'(state) == 0)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                n_checks++; n_fail++;
                $display("FAIL %s: timeout, got state=%0d floor=%0d, required state=0", name, state, floor);
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 5'd0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_now("reset_values", 0, 0, 2);
        mon_en = 1'b1;
        repeat (8) @(negedge clk);
        check_now("idle_no_calls", 0, 0, 2);

        press(5'b00001, 12);
        wait_idle(200, "same_floor");
        check_now("same_floor_final", 0, 0, 2);

        press(5'b10000, 2);
        wait_dut(4, 3, 200, "ascent_door_4");
        wait_idle(200, "ascent");
        check_now("ascent_final", 4, 0, 2);

        press(5'b01010, 2);
        wait_dut(1, 3, 200, "descent_door_1");
        wait_idle(200, "descent");
        check_now("descent_final", 1, 0, 2);

        press(5'b00001, 1);
        wait_idle(200, "return_to_0");
        press(5'b10000, 1);
        wait_dut(1, 1, 100, "collective_at_1");
        press(5'b00101, 1);
        wait_idle(400, "collective");
        check_now("collective_final", 0, 0, 2);

        press(5'b11000, 1);
        wait_dut(2, 1, 100, "travel_at_2");
        @(posedge clk); #2;
        rst = 1'b0;
        model_reset();
        #1 check_now("reset_mid_travel", 0, 0, 2);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (60) @(negedge clk);
        check_now("calls_discarded", 0, 0, 2);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 5; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 24) == 0) req[i] = 1'b1;
                end
            end
        end
        @(negedge clk); #1;
        req = 5'd0;
        wait_idle(800, "random_drain");
        repeat (4) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_changes: got %0d predicted changes never observed, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
